alu_serial_sched: RTL
=====================

Name: alu_serial_sched

Overview:
- Round-robin arbiter and sequencer that shares one serial ALU (single-bit sin/sout frame interface) between NREQ parallel requesters.
- Accepts {A, B, op} per requester, computes the CRC4, serializes the 99-bit command stream and deserializes the 55-bit or 11-bit reply.
- Returns result, flags or error to the winning requester over a tagged response channel.
- Sits between testbench/SoC agents and the DUT ALU; owns the ALU's serial port and its reset.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id, equal to clog2(NREQ)
TIMEOUT, 1023, cycles to wait for the reply start bit before aborting

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot, single-cycle
req_a  in  32*NREQ  operand A, requester i at [32i+31:32i]
req_b  in  32*NREQ  operand B, same packing
req_op  in  3*NREQ  opcode, passed to the ALU unchecked
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of the requester being answered
rsp_result  out  32  ALU result (0 unless status OK)
rsp_flags  out  4  ALU flags (0 unless status OK)
rsp_err  out  6  ALU error bits (0 unless status ALUERR)
rsp_status  out  2  00 OK, 01 ALUERR, 10 TIMEOUT, 11 FRAMING
sin  out  1  serial data to ALU, idle 1
sout  in  1  serial data from ALU, idle 1
alu_rst_n  out  1  ALU reset, active-low
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async): state IDLE, sin=1, alu_rst_n=1, req_ready=0, rsp_valid=0, all rsp_* = 0, RR pointer = 0. Reset mid-frame abandons the transaction silently; no response is issued.
- Frame format: 11 bits, MSB first, one bit per clk. sin is registered and updates on posedge; sout is sampled on posedge.
  - Data frame: 0,0,d[7:0],1.
  - Command frame: 0,1,0,op[2:0],crc[3:0],1.
- Command stream: 8 data frames, then 1 command frame (99 bits). Data bytes are B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] .. A[7:0].
- CRC4: polynomial x^4+x+1, init 0, over the 68-bit vector {B, A, 1'b1, op} MSB first. Computed combinationally at grant and latched.
- FSM:
  - IDLE: if any req_valid, ARB next cycle.
  - ARB: grant the first valid index at or after ptr (wrapping). Pulse req_ready[g] for 1 cycle. Latch operands, g and CRC. Set ptr=(g+1) mod NREQ. Go to SEND.
  - SEND: 99-bit counter; the first sin bit appears the cycle after ARB. After bit 98, sin=1 and go to WAIT.
  - WAIT: timer counts from 0. On sout==0, go to RECV (that bit is reply bit 54). If the timer reaches TIMEOUT, go to ARST.
  - RECV: shift in bits.
    - After 11 bits, check reply bit 53. If 1, it is an error frame 0,1,1,err[5:0],p,1: status ALUERR, rsp_err = its err bits, go to RESP.
    - If 0, collect 55 bits total: 4 data frames (result MSB byte first), then control frame 0,1,0,flags[3:0],crc3[2:0],1. Status OK, go to RESP.
    - Any stop bit == 0 gives status FRAMING; the rest of that frame is still consumed.
  - ARST: drive alu_rst_n=0 for 2 cycles. Status TIMEOUT, then RESP.
  - RESP: rsp_valid=1 with all rsp_* stable. On rsp_valid&rsp_ready, drop rsp_valid and go to IDLE.
- No new grant while busy; requests remain pending with valid held.
- Requesters must hold valid and operands stable until ready.
- Simultaneous valid from all: granted in order ptr, ptr+1, ...; starvation-free.
- rsp_ready held high: RESP lasts exactly 1 cycle.
- Latency: ARB to last sin bit = 99 cycles; response latency = 99 + ALU turnaround + 55 + 1 cycles.

Test Plan:
- Single req0: A=1, B=2, op=100 -> sin carries 8 data frames then command frame 0,1,0,1,0,0,crc,1; ALU reply 3 -> rsp_id=0, status 00, rsp_result=32'h3.
- req0..req3 all valid for the same cycle, after reset -> grants 0,1,2,3 in order; with req1 re-asserted after grant 3, next grant is 1 (pointer wrap).
- Invalid op=111 -> ALU error frame returns err=6'b001001 -> status 01, rsp_err=6'b001001, result and flags 0.
- sout held at 1 after the command -> after TIMEOUT=1023 cycles, alu_rst_n low for 2 cycles, status 10, busy drops after rsp_ready.
- rst_n asserted in SEND at bit 40 -> sin=1 immediately, no rsp_valid, next request restarts from grant index 0.
- rsp_ready held low 10 cycles -> rsp_valid and data stable for all 10 cycles; req_ready stays 0 throughout.

Source files
------------

// File: rtl/alu_serial_sched.sv
// alu_serial_sched: round-robin scheduler sharing one bit-serial ALU among NREQ requesters
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is a one-cycle one-hot grant
//   req_a/req_b/req_op    packed operands and opcode, requester i in slice i
//   rsp_*                 tagged response held until rsp_ready
//   sin/sout              11-bit serial frames to/from the ALU, idle high
//   alu_rst_n             ALU reset, pulsed low after a reply timeout
//   busy                  high whenever a transaction is in progress
module alu_serial_sched #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [5:0]        rsp_err,
  output logic [1:0]        rsp_status,
  output logic              sin,
  input  logic              sout,
  output logic              alu_rst_n,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT + 1) > 7 ? $clog2(TIMEOUT + 1) : 7;
  localparam logic [1:0] ST_OK = 2'b00;
  localparam logic [1:0] ST_ALUERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_FRAMING = 2'b11;

  typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT, RECV, ARST, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d, gnt, idx;
  logic            gnt_ok;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [98:0]     tx_q, tx_d, tx_load;
  logic [53:0]     rx_q, rx_d;
  logic            sin_q, sin_d, fe_q, fe_d;
  logic [31:0]     res_q, res_d, ga, gb;
  logic [3:0]      flg_q, flg_d;
  logic [5:0]      err_q, err_d;
  logic [1:0]      st_q, st_d;
  logic [2:0]      gop;
  logic            last_tx, bad_stop, rx_unused;

  function automatic logic [10:0] df(input logic [7:0] d);
    return {2'b00, d, 1'b1};
  endfunction

  // x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4(input logic [67:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 67; i >= 0; i--)
      c = {c[2:0], 1'b0} ^ ((c[3] ^ m[i]) ? 4'b0011 : 4'b0000);
    return c;
  endfunction

  // first valid index at or after the pointer, wrapping
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        gnt_ok = 1'b1;
      end
    end
  end

  assign ga = req_a[32*gnt +: 32];
  assign gb = req_b[32*gnt +: 32];
  assign gop = req_op[3*gnt +: 3];
  assign tx_load = {df(gb[31:24]), df(gb[23:16]), df(gb[15:8]), df(gb[7:0]),
                    df(ga[31:24]), df(ga[23:16]), df(ga[15:8]), df(ga[7:0]),
                    3'b010, gop, crc4({gb, ga, 1'b1, gop}), 1'b1};
  assign last_tx = cnt_q == CW'(98);
  // reply bit positions 10,21,32,43,54 are frame stop bits
  assign bad_stop = !sout && (cnt_q == CW'(10) || cnt_q == CW'(21) || cnt_q == CW'(32) ||
                              cnt_q == CW'(43) || cnt_q == CW'(54));
  // delimiter and check bits in the receive buffer are deliberately never decoded
  assign rx_unused = ^rx_q;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    tx_d = tx_q;
    rx_d = rx_q;
    sin_d = sin_q;
    fe_d = fe_q;
    res_d = res_q;
    flg_d = flg_q;
    err_d = err_q;
    st_d = st_q;
    req_ready = '0;
    case (state_q)
      IDLE: state_d = |req_valid ? ARB : IDLE;
      ARB: begin
        state_d = gnt_ok ? SEND : IDLE;
        if (gnt_ok) begin
          req_ready[gnt] = 1'b1;
          id_d = gnt;
          ptr_d = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
          sin_d = tx_load[98];
          tx_d = {tx_load[97:0], 1'b1};
          cnt_d = '0;
        end
      end
      SEND: begin
        sin_d = last_tx ? 1'b1 : tx_q[98];
        tx_d = {tx_q[97:0], 1'b1};
        cnt_d = last_tx ? '0 : cnt_q + CW'(1);
        state_d = last_tx ? WAIT : SEND;
      end
      WAIT: begin
        rx_d = '0;
        fe_d = 1'b0;
        if (!sout) begin
          cnt_d = CW'(1);
          state_d = RECV;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          cnt_d = '0;
          state_d = ARST;
        end else
          cnt_d = cnt_q + CW'(1);
      end
      RECV: begin
        rx_d = {rx_q[52:0], sout};
        cnt_d = cnt_q + CW'(1);
        fe_d = fe_q | bad_stop;
        // rx_q[8] is the second reply bit: 1 marks a short error frame
        if (cnt_q == CW'(10) && rx_q[8]) begin
          st_d = fe_d ? ST_FRAMING : ST_ALUERR;
          err_d = fe_d ? '0 : rx_q[6:1];
          res_d = '0;
          flg_d = '0;
          state_d = RESP;
        end else if (cnt_q == CW'(54)) begin
          st_d = fe_d ? ST_FRAMING : ST_OK;
          res_d = fe_d ? '0 : {rx_q[51:44], rx_q[40:33], rx_q[29:22], rx_q[18:11]};
          flg_d = fe_d ? '0 : rx_q[6:3];
          err_d = '0;
          state_d = RESP;
        end
      end
      ARST: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(1)) begin
          st_d = ST_TIMEOUT;
          res_d = '0;
          flg_d = '0;
          err_d = '0;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      tx_q <= '1;
      rx_q <= '0;
      sin_q <= 1'b1;
      fe_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      err_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      sin_q <= sin_d;
      fe_q <= fe_d;
      res_q <= res_d;
      flg_q <= flg_d;
      err_q <= err_d;
      st_q <= st_d;
    end

  assign sin = sin_q;
  assign alu_rst_n = state_q != ARST;
  assign busy = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_flags = flg_q;
  assign rsp_err = err_q;
  assign rsp_status = st_q;
endmodule
